ssd_scan_driver: RTL and testbench
==================================

SSD_SCAN_DRIVER -- requirements
Module: ssd_scan_driver

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 100000, meaning clk cycles per digit step (1 kHz digit rate at 100 MHz).
REQ-002 SHALL have parameter BLINK_DIV, default 50000000, meaning clk cycles per blink-phase toggle (1 Hz blink at 100 MHz).
REQ-003 SHALL have port clk  input  1  single system clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port chars  input  20  four 5-bit character codes; [19:15] is digit 0 (leftmost), [4:0] is digit 3 (rightmost).
REQ-006 SHALL have port blink_mask  input  4  bit 3 = digit 0 ... bit 0 = digit 3; 1 means the digit blinks.
REQ-007 SHALL have port an  output  4  anode enables, active-low, one-hot-zero; an[3] = digit 0.
REQ-008 SHALL have port seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-009 SHALL have port dp  output  1  decimal point, active-low, held at 1.
REQ-010 SHALL have port frame_tick  output  1  one-cycle pulse on each digit-3-to-digit-0 wrap.

Function
REQ-011 SHALL decode codes: 5'h00-5'h0F hex digits 0-F; 5'h10 blank; 5'h11 dash; 5'h12 C; 5'h13 L; 5'h14 O; 5'h15 P; 5'h16 n; 5'h17 r; 5'h18-5'h1F blank.
REQ-012 SHALL run prescaler 0..SCAN_DIV-1; scan_tick asserts for one cycle at SCAN_DIV-1, after which the prescaler wraps to 0.
REQ-013 SHALL advance digit index 0->1->2->3->0 on each scan_tick; there is no other transition.
REQ-014 SHALL load the shadow register from chars and blink_mask on the scan_tick that wraps index 3->0, and on the first cycle after reset release; it SHALL ignore input changes at all other times (no tearing within a frame).
REQ-015 SHALL pulse frame_tick high for exactly the cycle in which the 3->0 wrap occurs.
REQ-016 SHALL run blink counter 0..BLINK_DIV-1, independent of the scan, and toggle blink_phase at BLINK_DIV-1.
REQ-017 SHALL drive a digit, when blink_phase=1 and that digit's shadow blink bit=1, as an deasserted for that slot (1111) and seg=7'h7F; all other digits are unaffected.
REQ-018 SHALL register an and seg, each reflecting the index/shadow/blink_phase of the previous cycle (one-cycle latency).
REQ-019 SHALL drive an and seg to 1111 / 7'h7F for the single cycle following each index change (anti-ghost blanking), then show the new digit.
REQ-020 SHALL allow a blink-phase toggle and a scan_tick in the same cycle, with both taking effect independently.
REQ-021 SHALL accept chars and blink_mask asynchronously to frame boundaries; values held under one cycle between loads are never displayed.

Reset
REQ-022 SHALL, while rst=1: prescaler=0, index=0, blink counter=0, blink_phase=0 (visible), shadow chars all 5'h10, shadow mask 0, an=4'b1111, seg=7'h7F, dp=1, frame_tick=0.
REQ-023 SHALL, when rst is asserted mid-frame, take effect on the next edge, with no partial digit retained.

Structure
REQ-024 SHALL place character-code constants (BLANK, DASH, CH_C, CH_L, CH_O, CH_P, CH_N, CH_R) in shared package ssd_pkg, which the lock ASM also uses.
REQ-025 SHALL implement the code-to-segment decode as combinational sub-module binary_to_segment (5-bit in, 7-bit active-low out), instantiated once.

Verification (SCAN_DIV=4, BLINK_DIV=16)
REQ-026 SHALL check reset release with chars={C,L,5,d}, mask 0 -> an sequence 0111,1011,1101,1110, each preceded by one blank cycle; seg for C=7'b1000110, L=7'b1000111, 5=7'b0010010, d=7'b0100001.
REQ-027 SHALL check that chars changed to {dash,3,blank,blank} while index=1 -> the current frame still shows C L 5 d; the next frame shows dash,3,blank,blank; frame_tick fires once per 16 cycles.
REQ-028 SHALL check mask=4'b1000, chars={7,blank,blank,blank} -> digit 0 shows 7 for 16 cycles, then an=1111 in its slot for 16 cycles, repeating.
REQ-029 SHALL check codes 5'h18-5'h1F -> seg=7'h7F with the anode still active.
REQ-030 SHALL check that rst asserted for 1 cycle at index=2 -> the next cycle has an=1111 and seg=7'h7F, and the scan restarts at digit 0 with blank shadow loaded from the current chars.

Source files
------------

// File: rtl/ssd_pkg.sv
// rtl/ssd_pkg.sv - shared character codes and display constants for the seven-segment driver
package ssd_pkg;

    // Non-hex glyph codes; the lock ASM builds its messages from these too
    localparam logic [4:0] BLANK = 5'h10;
    localparam logic [4:0] DASH  = 5'h11;
    localparam logic [4:0] CH_C  = 5'h12;
    localparam logic [4:0] CH_L  = 5'h13;
    localparam logic [4:0] CH_O  = 5'h14;
    localparam logic [4:0] CH_P  = 5'h15;
    localparam logic [4:0] CH_N  = 5'h16;
    localparam logic [4:0] CH_R  = 5'h17;

    // All-off patterns (outputs are active-low)
    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [3:0] AN_OFF  = 4'b1111;

    typedef logic [1:0] digit_idx_t;

    // Active-low anode for a digit slot; digit 0 (leftmost) is an[3]
    function automatic logic [3:0] anode_for(input digit_idx_t idx);
        return ~(4'b1000 >> idx);
    endfunction

endpackage

// File: rtl/binary_to_segment.sv
// rtl/binary_to_segment.sv - 5-bit character code to active-low {g,f,e,d,c,b,a} segment pattern
module binary_to_segment
    import ssd_pkg::*;
(
    input  logic [4:0] code,
    output logic [6:0] seg
);

    // Glyph table; blank and every unassigned code fall through to all-off
    always_comb begin
        seg = SEG_OFF;
        case (code)
            5'h00: seg = 7'b1000000;
            5'h01: seg = 7'b1111001;
            5'h02: seg = 7'b0100100;
            5'h03: seg = 7'b0110000;
            5'h04: seg = 7'b0011001;
            5'h05: seg = 7'b0010010;
            5'h06: seg = 7'b0000010;
            5'h07: seg = 7'b1111000;
            5'h08: seg = 7'b0000000;
            5'h09: seg = 7'b0010000;
            5'h0A: seg = 7'b0001000;
            5'h0B: seg = 7'b0000011;
            5'h0C: seg = 7'b1000110;
            5'h0D: seg = 7'b0100001;
            5'h0E: seg = 7'b0000110;
            5'h0F: seg = 7'b0001110;
            DASH:  seg = 7'b0111111;
            CH_C:  seg = 7'b1000110;
            CH_L:  seg = 7'b1000111;
            CH_O:  seg = 7'b1000000;
            CH_P:  seg = 7'b0001100;
            CH_N:  seg = 7'b0101011;
            CH_R:  seg = 7'b0101111;
            default: seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/ssd_scan_driver.sv
// rtl/ssd_scan_driver.sv - four-digit multiplexed seven-segment scan driver with per-digit blink
module ssd_scan_driver
    import ssd_pkg::*;
#(
    parameter int SCAN_DIV  = 100000,
    parameter int BLINK_DIV = 50000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [19:0] chars,
    input  logic [3:0]  blink_mask,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_tick
);

    localparam int PW = $clog2(SCAN_DIV + 1);
    localparam int BW = $clog2(BLINK_DIV + 1);
    localparam logic [PW-1:0] SCAN_LAST  = PW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    logic [PW-1:0] prescaler;
    logic [BW-1:0] blink_cnt;
    logic          blink_phase;
    digit_idx_t    index;
    logic [19:0]   shadow_chars;
    logic [3:0]    shadow_mask;
    logic          load_pending;
    logic          scan_tick;
    logic          wrap;
    logic [4:0]    cur_code;
    logic          cur_blink;
    logic [6:0]    dec_seg;

    assign scan_tick  = (prescaler == SCAN_LAST);
    assign wrap       = scan_tick && (index == 2'd3);
    assign frame_tick = wrap;
    assign dp         = 1'b1;

    // Digit-rate prescaler and scan index
    always_ff @(posedge clk) begin
        if (rst) begin
            prescaler <= '0;
            index     <= 2'd0;
        end else if (scan_tick) begin
            prescaler <= '0;
            index     <= index + 2'd1;
        end else begin
            prescaler <= prescaler + 1'b1;
        end
    end

    // Free-running blink timebase, unrelated to the scan
    always_ff @(posedge clk) begin
        if (rst) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    // Frame snapshot of chars/mask: taken once after reset and at every frame wrap only
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_chars <= {4{BLANK}};
            shadow_mask  <= 4'b0000;
            load_pending <= 1'b1;
        end else if (load_pending || wrap) begin
            shadow_chars <= chars;
            shadow_mask  <= blink_mask;
            load_pending <= 1'b0;
        end
    end

    // Pick the current digit's code and blink bit out of the snapshot
    always_comb begin
        cur_code  = shadow_chars[19:15];
        cur_blink = shadow_mask[3];
        case (index)
            2'd0: begin cur_code = shadow_chars[19:15]; cur_blink = shadow_mask[3]; end
            2'd1: begin cur_code = shadow_chars[14:10]; cur_blink = shadow_mask[2]; end
            2'd2: begin cur_code = shadow_chars[9:5];   cur_blink = shadow_mask[1]; end
            default: begin cur_code = shadow_chars[4:0]; cur_blink = shadow_mask[0]; end
        endcase
    end

    binary_to_segment u_decode (
        .code (cur_code),
        .seg  (dec_seg)
    );

    // Registered outputs; blank the cycle after any index change (and the snapshot cycle) to stop ghosting
    always_ff @(posedge clk) begin
        if (rst) begin
            an  <= AN_OFF;
            seg <= SEG_OFF;
        end else if (scan_tick || load_pending || (blink_phase && cur_blink)) begin
            an  <= AN_OFF;
            seg <= SEG_OFF;
        end else begin
            an  <= anode_for(index);
            seg <= dec_seg;
        end
    end

endmodule

// File: tb/tb_ssd_scan_driver.sv
// tb/tb_ssd_scan_driver.sv - directed self-checking bench for ssd_scan_driver
module tb_ssd_scan_driver;
    import ssd_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [19:0] chars;
    logic [3:0]  blink_mask;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_tick;

    int checks   = 0;
    int errors   = 0;
    int cyc      = 0;
    int ft_count = 0;

    always #5 clk = ~clk;

    ssd_scan_driver #(
        .SCAN_DIV  (4),
        .BLINK_DIV (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .chars      (chars),
        .blink_mask (blink_mask),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_tick (frame_tick)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (frame_tick === 1'b1) ft_count++;
    endtask

    task automatic run_to(input int k);
        while (cyc < k) tick();
    endtask

    task automatic check_disp(input string tag, input logic [3:0] ean, input logic [6:0] eseg);
        check_eq({tag, ".an"}, {28'd0, an}, {28'd0, ean});
        check_eq({tag, ".seg"}, {25'd0, seg}, {25'd0, eseg});
    endtask

    initial begin
        rst        = 1'b1;
        chars      = {CH_C, CH_L, 5'h05, 5'h0D};
        blink_mask = 4'b0000;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        check_disp("reset", 4'b1111, 7'h7F);
        check_eq("reset.dp", {31'd0, dp}, 32'd1);
        check_eq("reset.ft", {31'd0, frame_tick}, 32'd0);

        rst      = 1'b0;
        cyc      = 0;
        ft_count = 0;

        // First frame: C L 5 d, each digit preceded by a blank cycle
        run_to(1);  check_disp("rel_blank", 4'b1111, 7'h7F);
        run_to(2);  check_disp("d0_C", 4'b0111, 7'b1000110);
        run_to(4);  check_disp("gap01", 4'b1111, 7'h7F);
        run_to(5);  check_disp("d1_L", 4'b1011, 7'b1000111);
        run_to(6);
        chars = {DASH, 5'h03, BLANK, BLANK};
        run_to(8);  check_disp("gap12", 4'b1111, 7'h7F);
        run_to(9);  check_disp("d2_5_held", 4'b1101, 7'b0010010);
        run_to(12); check_disp("gap23", 4'b1111, 7'h7F);
        run_to(13); check_disp("d3_d_held", 4'b1110, 7'b0100001);
        run_to(14); check_eq("ft_14", {31'd0, frame_tick}, 32'd0);
        run_to(15); check_eq("ft_15", {31'd0, frame_tick}, 32'd1);
        run_to(16); check_disp("gap30", 4'b1111, 7'h7F);

        // Second frame shows the chars written mid-frame
        run_to(17); check_disp("f2_dash", 4'b0111, 7'b0111111);
        chars      = {5'h07, BLANK, BLANK, BLANK};
        blink_mask = 4'b1000;
        run_to(21); check_disp("f2_3", 4'b1011, 7'b0110000);
        run_to(25); check_disp("f2_blank", 4'b1101, 7'h7F);

        // Blink on digit 0: visible in phase 0, dark in phase 1
        run_to(33); check_disp("blink_vis", 4'b0111, 7'b1111000);
        run_to(35); check_disp("blink_vis2", 4'b0111, 7'b1111000);
        run_to(49); check_disp("blink_dark", 4'b1111, 7'h7F);
        run_to(50);
        chars      = {5'h18, 5'h1F, 5'h1A, 5'h1C};
        blink_mask = 4'b0000;
        run_to(51); check_disp("blink_dark2", 4'b1111, 7'h7F);
        run_to(53); check_disp("blink_other", 4'b1011, 7'h7F);

        // Unassigned codes: anode on, segments off
        run_to(65); check_disp("code18", 4'b0111, 7'h7F);
        run_to(66);
        chars = {CH_R, CH_N, CH_O, CH_P};
        run_to(69); check_disp("code1F", 4'b1011, 7'h7F);

        // Letters
        run_to(81); check_disp("ch_r", 4'b0111, 7'b0101111);
        run_to(85); check_disp("ch_n", 4'b1011, 7'b0101011);
        run_to(89); check_disp("ch_o", 4'b1101, 7'b1000000);

        // One frame_tick per 16 cycles so far
        run_to(90); check_eq("ft_count", ft_count, 32'd5);

        // One-cycle reset at index 2
        rst   = 1'b1;
        chars = {5'h01, 5'h02, 5'h0A, 5'h0E};
        tick();
        check_disp("mid_rst", 4'b1111, 7'h7F);
        check_eq("mid_rst.ft", {31'd0, frame_tick}, 32'd0);
        rst = 1'b0;
        run_to(92);  check_disp("rst_blank", 4'b1111, 7'h7F);
        run_to(93);  check_disp("rst_d0", 4'b0111, 7'b1111001);
        run_to(95);  check_disp("rst_gap", 4'b1111, 7'h7F);
        run_to(96);  check_disp("rst_d1", 4'b1011, 7'b0100100);
        run_to(105); check_eq("rst_ft_105", {31'd0, frame_tick}, 32'd0);
        run_to(106); check_eq("rst_ft_106", {31'd0, frame_tick}, 32'd1);
        check_eq("dp_hold", {31'd0, dp}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
